// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx
// ----------------------------------------------------------------------------
// Purpose:
//   Asynchronous serial receiver, the receive-side partner of uart_tx.
//   Frame format: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit,
//   1 stop bit (1). Every frame that survives the mid-start-bit check is
//   reported with a one-cycle strobe plus parity/framing error flags; the
//   consumer decides whether to keep errored bytes.
//
// Parameters:
//   BAUD_RATE       line bit rate in bits/s
//   EXTERNAL_CLOCK  clk frequency in Hz
//
// Ports:
//   clk           in   1  system clock, rising edge
//   sync_nreset   in   1  synchronous active-low reset
//   data_in       in   1  serial RX line, asynchronous, idle high
//   data_out      out  8  last received byte, held until the next frame
//   data_valid    out  1  one-cycle strobe per completed frame
//   parity_error  out  1  received parity differs from even parity of data
//   frame_error   out  1  sampled stop bit was 0
// ============================================================================
module uart_rx #(
    parameter int BAUD_RATE      = 115_200,
    parameter int EXTERNAL_CLOCK = 50_000_000
) (
    input  logic       clk,
    input  logic       sync_nreset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       frame_error
);

    localparam int CLKS_PER_BIT = EXTERNAL_CLOCK / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    // REPORT is the single cycle after the stop sample in which the frame
    // results are published; it keeps the output registers off the
    // counter-compare path.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        REPORT,
        WAIT_HIGH
    } state_t;

    state_t state;
    state_t next_state;

    logic             sync_q1;
    logic             rx_s;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             rx_par;
    logic             stop_sample;

    logic cnt_clear;
    logic cnt_inc;
    logic shift_en;
    logic idx_clear;
    logic par_en;
    logic stop_en;
    logic report_en;

    // Two-flop synchroniser. Reset forces the idle (high) level so that a
    // reset does not itself look like a start edge.
    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            sync_q1 <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_q1 <= data_in;
            rx_s    <= sync_q1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control. The start bit is checked at half a
    // bit period so that every later sample, taken a full period apart,
    // lands in the centre of its bit.
    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        shift_en   = 1'b0;
        idx_clear  = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;
        report_en  = 1'b0;

        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                idx_clear = 1'b1;
                if (!rx_s) begin
                    next_state = START;
                end
            end

            START: begin
                if (clk_cnt == CNT_HALF) begin
                    cnt_clear  = 1'b1;
                    next_state = rx_s ? IDLE : DATA;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            DATA: begin
                if (clk_cnt == CNT_FULL) begin
                    cnt_clear = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_idx == 3'd7) begin
                        next_state = PARITY;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            PARITY: begin
                if (clk_cnt == CNT_FULL) begin
                    cnt_clear  = 1'b1;
                    par_en     = 1'b1;
                    next_state = STOP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            STOP: begin
                if (clk_cnt == CNT_FULL) begin
                    cnt_clear  = 1'b1;
                    stop_en    = 1'b1;
                    next_state = REPORT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            // A low stop bit may be the start of a break; wait for the line
            // to go high before looking for another start edge.
            REPORT: begin
                cnt_clear  = 1'b1;
                report_en  = 1'b1;
                next_state = stop_sample ? IDLE : WAIT_HIGH;
            end

            WAIT_HIGH: begin
                cnt_clear = 1'b1;
                if (rx_s) begin
                    next_state = IDLE;
                end
            end

            default: begin
                cnt_clear  = 1'b1;
                next_state = IDLE;
            end
        endcase
    end

    // Bit-period counter and bit index.
    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            clk_cnt <= '0;
            bit_idx <= '0;
        end else begin
            if (cnt_clear) begin
                clk_cnt <= '0;
            end else if (cnt_inc) begin
                clk_cnt <= clk_cnt + 1'b1;
            end

            if (idx_clear) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // Sample capture: data bits, parity bit and stop bit.
    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            shift       <= '0;
            rx_par      <= 1'b0;
            stop_sample <= 1'b1;
        end else begin
            if (shift_en) begin
                shift[bit_idx] <= rx_s;
            end
            if (par_en) begin
                rx_par <= rx_s;
            end
            if (stop_en) begin
                stop_sample <= rx_s;
            end
        end
    end

    // Frame results. data_out and the error flags only change on a report,
    // so they stay valid for the consumer until the next frame completes.
    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            data_out     <= 8'h00;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            data_valid <= report_en;
            if (report_en) begin
                data_out     <= shift;
                parity_error <= rx_par ^ (^shift);
                frame_error  <= ~stop_sample;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx
// ----------------------------------------------------------------------------
// Directed bench for uart_rx at the default 115200 baud / 50 MHz settings.
// Frames are driven bit by bit on the falling clock edge; a monitor logs
// every data_valid cycle with its byte, flags and rising-edge index.
// ============================================================================
module tb_uart_rx;

    localparam int CPB     = 50_000_000 / 115_200;
    localparam int LATENCY = 4560;

    logic       clk;
    logic       sync_nreset;
    logic       data_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;
    int last_start_edge = 0;

    logic [7:0] pd[$];
    logic       pp[$];
    logic       pf[$];
    int         pe[$];

    uart_rx dut (
        .clk          (clk),
        .sync_nreset  (sync_nreset),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .frame_error  (frame_error)
    );

    // 100 MHz simulation clock; the period value is irrelevant to the DUT.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge index, used to measure latency in cycles.
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Log every cycle where data_valid is high, sampled mid-cycle.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            pd.push_back(data_out);
            pp.push_back(parity_error);
            pf.push_back(frame_error);
            pe.push_back(cycle_cnt);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one complete frame starting at a falling edge. When rst_bit
    // matches a frame bit position (0 = start bit), a one-cycle reset is
    // applied 200 cycles into that bit and the outputs are checked.
    task automatic applyStimulus(input logic [7:0] d, input logic par,
                                 input logic stp, input int rst_bit);
        logic [10:0] frame;
        frame = {stp, par, d, 1'b0};
        last_start_edge = cycle_cnt + 1;
        for (int i = 0; i < 11; i++) begin
            data_in = frame[i];
            for (int j = 0; j < CPB; j++) begin
                if (i == rst_bit && j == 200) sync_nreset = 1'b0;
                @(negedge clk);
                if (i == rst_bit && j == 200) begin
                    sync_nreset = 1'b1;
                    checkOutput("midrst_data_out", 32'(data_out), 32'h00);
                    checkOutput("midrst_valid", 32'(data_valid), 32'h0);
                    checkOutput("midrst_perr", 32'(parity_error), 32'h0);
                    checkOutput("midrst_ferr", 32'(frame_error), 32'h0);
                end
            end
        end
    endtask

    initial begin
        int n0;
        int e0;

        sync_nreset = 1'b0;
        data_in     = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_data_out", 32'(data_out), 32'h00);
        checkOutput("rst_valid", 32'(data_valid), 32'h0);
        checkOutput("rst_perr", 32'(parity_error), 32'h0);
        checkOutput("rst_ferr", 32'(frame_error), 32'h0);
        sync_nreset = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] frame 0xBD, good parity and stop");
        n0 = pd.size();
        applyStimulus(8'hBD, 1'b0, 1'b1, -1);
        checkOutput("bd_count", 32'(pd.size()), 32'(n0 + 1));
        if (pd.size() == n0 + 1) begin
            checkOutput("bd_data", 32'(pd[n0]), 32'hBD);
            checkOutput("bd_perr", 32'(pp[n0]), 32'h0);
            checkOutput("bd_ferr", 32'(pf[n0]), 32'h0);
            checkOutput("bd_latency", 32'(pe[n0] - last_start_edge), 32'(LATENCY));
        end
        checkOutput("bd_hold", 32'(data_out), 32'hBD);
        checkOutput("bd_valid_low", 32'(data_valid), 32'h0);
        repeat (CPB) @(negedge clk);

        $display("[TB] frame 0x01 with wrong parity");
        n0 = pd.size();
        applyStimulus(8'h01, 1'b0, 1'b1, -1);
        checkOutput("p01_count", 32'(pd.size()), 32'(n0 + 1));
        if (pd.size() == n0 + 1) begin
            checkOutput("p01_data", 32'(pd[n0]), 32'h01);
            checkOutput("p01_perr", 32'(pp[n0]), 32'h1);
            checkOutput("p01_ferr", 32'(pf[n0]), 32'h0);
        end
        checkOutput("p01_perr_hold", 32'(parity_error), 32'h1);
        repeat (CPB) @(negedge clk);

        $display("[TB] frame 0x55 with low stop bit, then break");
        n0 = pd.size();
        applyStimulus(8'h55, 1'b0, 1'b0, -1);
        checkOutput("brk_count", 32'(pd.size()), 32'(n0 + 1));
        if (pd.size() == n0 + 1) begin
            checkOutput("brk_data", 32'(pd[n0]), 32'h55);
            checkOutput("brk_perr", 32'(pp[n0]), 32'h0);
            checkOutput("brk_ferr", 32'(pf[n0]), 32'h1);
        end
        repeat (20 * CPB) @(negedge clk);
        checkOutput("brk_low_no_pulse", 32'(pd.size()), 32'(n0 + 1));
        data_in = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("brk_high_no_pulse", 32'(pd.size()), 32'(n0 + 1));
        checkOutput("brk_ferr_hold", 32'(frame_error), 32'h1);

        $display("[TB] 100-cycle glitch, then frame 0xA3");
        n0 = pd.size();
        data_in = 1'b0;
        repeat (100) @(negedge clk);
        data_in = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("glitch_no_pulse", 32'(pd.size()), 32'(n0));
        applyStimulus(8'hA3, 1'b0, 1'b1, -1);
        checkOutput("a3_count", 32'(pd.size()), 32'(n0 + 1));
        if (pd.size() == n0 + 1) begin
            checkOutput("a3_data", 32'(pd[n0]), 32'hA3);
            checkOutput("a3_perr", 32'(pp[n0]), 32'h0);
            checkOutput("a3_ferr", 32'(pf[n0]), 32'h0);
        end
        repeat (CPB) @(negedge clk);

        $display("[TB] back-to-back frames 0x00 0xFF 0x5A");
        n0 = pd.size();
        applyStimulus(8'h00, 1'b0, 1'b1, -1);
        e0 = last_start_edge;
        applyStimulus(8'hFF, 1'b0, 1'b1, -1);
        applyStimulus(8'h5A, 1'b0, 1'b1, -1);
        checkOutput("b2b_count", 32'(pd.size()), 32'(n0 + 3));
        if (pd.size() == n0 + 3) begin
            checkOutput("b2b_data0", 32'(pd[n0]), 32'h00);
            checkOutput("b2b_data1", 32'(pd[n0 + 1]), 32'hFF);
            checkOutput("b2b_data2", 32'(pd[n0 + 2]), 32'h5A);
            checkOutput("b2b_err", 32'({pp[n0], pp[n0 + 1], pp[n0 + 2],
                                        pf[n0], pf[n0 + 1], pf[n0 + 2]}), 32'h0);
            checkOutput("b2b_latency0", 32'(pe[n0] - e0), 32'(LATENCY));
            checkOutput("b2b_gap01", 32'(pe[n0 + 1] - pe[n0]), 32'(11 * CPB));
            checkOutput("b2b_gap12", 32'(pe[n0 + 2] - pe[n0 + 1]), 32'(11 * CPB));
        end
        repeat (CPB) @(negedge clk);

        $display("[TB] reset during data bit 4, then frame 0xC3");
        n0 = pd.size();
        applyStimulus(8'hF1, 1'b1, 1'b1, 5);
        repeat (CPB) @(negedge clk);
        checkOutput("abort_no_pulse", 32'(pd.size()), 32'(n0));
        applyStimulus(8'hC3, 1'b0, 1'b1, -1);
        checkOutput("c3_count", 32'(pd.size()), 32'(n0 + 1));
        if (pd.size() == n0 + 1) begin
            checkOutput("c3_data", 32'(pd[n0]), 32'hC3);
            checkOutput("c3_perr", 32'(pp[n0]), 32'h0);
            checkOutput("c3_ferr", 32'(pf[n0]), 32'h0);
        end
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
